fetch_unit: RTL and testbench

Instruction-fetch stage that owns the program counter, requests instructions from instruction memory over a ready handshake, and holds the current instruction in a decode register. The register's opcode field drives the control unit's `OpCode` input directly. Control-unit outputs (`BranchEq`, `BranchGr`, `Jump`) and the ALU compare flags return here to select the next PC. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

---
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the program counter and requests words from instruction memory over a
// req/ready handshake. It holds the current instruction in a decode register
// whose opcode field feeds the control unit. The control-unit and ALU compare
// results select the next PC when decode consumes an instruction.
// A one-entry skid buffer absorbs a response that arrives while decode is stalled.
// A taken redirect while a request is still outstanding sets a squash flag,
// so the stale response is dropped when it finally arrives.
// Optional feature macro: FETCH_PERF_EN adds the fetch_count/stall_count
// counters. Without it, both outputs read zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_eq_i,
    input  logic        branch_gr_i,
    input  logic        jump_i,
    input  logic        alu_zero_i,
    input  logic        alu_gt_i,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [5:0]  dec_opcode,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] old_addr_q;     // address of the outstanding request while squashing
    logic        squash_q;
    logic [31:0] skid_q;         // skid word; its PC is pc_q (not yet advanced)
    logic        dec_valid_q;
    logic [31:0] dec_instr_q;
    logic [31:0] dec_pc_q;
    logic [31:0] dec_pc_plus4_q;

    logic        consume_s;
    logic        taken_s;
    logic        redirect_s;
    logic        load_fetch_s;
    logic        load_skid_s;
    logic [31:0] br_target_s;
    logic [31:0] jmp_target_s;
    logic [31:0] target_d;
    logic [31:0] seq_pc_d;

    // Consume/redirect decision, next-PC candidates and decode-load qualifiers.
    always_comb begin
        consume_s    = dec_valid_q & ~stall;
        taken_s      = (branch_eq_i & alu_zero_i) | (branch_gr_i & alu_gt_i) | jump_i;
        redirect_s   = consume_s & taken_s;
        br_target_s  = dec_pc_plus4_q + {{14{dec_instr_q[15]}}, dec_instr_q[15:0], 2'b00};
        jmp_target_s = {dec_pc_plus4_q[31:28], dec_instr_q[25:0], 2'b00};
        target_d     = jump_i ? jmp_target_s : br_target_s;
        seq_pc_d     = pc_q + 32'd4;
        load_fetch_s = (state_q == S_FETCH) & imem_ready & ~squash_q & ~redirect_s
                       & ~(dec_valid_q & stall);
        load_skid_s  = (state_q == S_SKID) & ~stall & ~redirect_s;
    end

    // Memory request decoded from state and address registers only.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (state_q == S_FETCH) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
        if (squash_q) begin
            imem_addr = old_addr_q;
        end else begin
            imem_addr = pc_q;
        end
    end

    // Fetch FSM together with the PC, squash, skid and decode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_PC;
            old_addr_q     <= RESET_PC;
            squash_q       <= 1'b0;
            skid_q         <= 32'd0;
            dec_valid_q    <= 1'b0;
            dec_instr_q    <= 32'd0;
            dec_pc_q       <= 32'd0;
            dec_pc_plus4_q <= 32'd0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        squash_q <= 1'b0;
                        if (load_fetch_s) begin
                            dec_instr_q    <= imem_rdata;
                            dec_pc_q       <= pc_q;
                            dec_pc_plus4_q <= seq_pc_d;
                            dec_valid_q    <= 1'b1;
                            pc_q           <= seq_pc_d;
                        end else if (redirect_s) begin
                            pc_q        <= target_d;
                            dec_valid_q <= 1'b0;
                        end else if (squash_q) begin
                            dec_valid_q <= dec_valid_q & ~consume_s;
                        end else begin
                            // Decode holds a stalled instruction: park the word.
                            skid_q  <= imem_rdata;
                            state_q <= S_SKID;
                        end
                    end else begin
                        if (redirect_s) begin
                            // Outstanding request keeps its old address; drop its data later.
                            pc_q        <= target_d;
                            old_addr_q  <= imem_addr;
                            squash_q    <= 1'b1;
                            dec_valid_q <= 1'b0;
                        end else begin
                            dec_valid_q <= dec_valid_q & ~consume_s;
                        end
                    end
                end
                S_SKID: begin
                    if (load_skid_s) begin
                        dec_instr_q    <= skid_q;
                        dec_pc_q       <= pc_q;
                        dec_pc_plus4_q <= seq_pc_d;
                        pc_q           <= seq_pc_d;
                        state_q        <= S_FETCH;
                    end else if (redirect_s) begin
                        pc_q        <= target_d;
                        dec_valid_q <= 1'b0;
                        state_q     <= S_FETCH;
                    end else begin
                        state_q <= S_SKID;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign dec_valid    = dec_valid_q;
    assign dec_instr    = dec_instr_q;
    assign dec_opcode   = dec_instr_q[31:26];
    assign dec_pc       = dec_pc_q;
    assign dec_pc_plus4 = dec_pc_plus4_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    // Wrapping counters of decode-register loads and stalled-decode cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            if (load_fetch_s | load_skid_s) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (dec_valid_q & stall) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory responder with variable latency, a
// control-unit stand-in that decodes dec_opcode, and a scoreboard that checks
// the architectural instruction stream against a PC-level reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        branch_eq_i = 1'b0, branch_gr_i = 1'b0, jump_i = 1'b0;
    logic        alu_zero_i = 1'b0, alu_gt_i = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [5:0]  dec_opcode;
    logic [31:0] dec_pc, dec_pc_plus4, fetch_count, stall_count;

    int checks = 0;
    int failures = 0;

    // Test control knobs (written only by the main sequence)
    int lat_mode   = 0;   // 0..3 fixed wait cycles, 4 = random 0..3
    int stall_mode = 0;   // 0 = manual stall_man, 1 = random
    int ctl_mode   = 0;   // 0 = controls off, 1 = decoded + zero=1, 2 = decoded + random flags
    logic stall_man = 1'b0;

    bit [31:0] ovr [bit [31:0]];
    logic [31:0] req_log [$];
    logic [31:0] exp_q [$];
    int n_cons = 0;
    int n_stall = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall),
        .branch_eq_i(branch_eq_i), .branch_gr_i(branch_gr_i), .jump_i(jump_i),
        .alu_zero_i(alu_zero_i), .alu_gt_i(alu_gt_i),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_opcode(dec_opcode),
        .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    always #10 clk = ~clk;

    // Program memory: a fixed hash of the address, biased toward j/beq/bgt opcodes.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (ovr.exists(a)) return ovr[a];
        h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        h = h ^ (h >> 15);
        h = h * 32'h2C1B_3C6D;
        h = h ^ (h >> 12);
        case (h[3:0])
            4'd0:    return {6'd2, h[29:4]};
            4'd1:    return {6'd4, h[29:4]};
            4'd2:    return {6'd7, h[29:4]};
            default: return h;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},    32'(imem_req), 32'd0);
        chk({tag, "_addr"},   imem_addr, RST_PC);
        chk({tag, "_valid"},  32'(dec_valid), 32'd0);
        chk({tag, "_instr"},  dec_instr, 32'd0);
        chk({tag, "_opcode"}, 32'(dec_opcode), 32'd0);
        chk({tag, "_pc"},     dec_pc, 32'd0);
        chk({tag, "_pc4"},    dec_pc_plus4, 32'd0);
        chk({tag, "_fcnt"},   fetch_count, 32'd0);
        chk({tag, "_scnt"},   stall_count, 32'd0);
    endtask

    // Assert reset asynchronously between edges, check it took effect at once,
    // then release it just after a rising edge so boot lasts exactly one cycle.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #6 rst_n = 1'b0;
        #1 chk_reset_vals(tag);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Memory responder: latches each new request, checks it stays stable, answers after the wait.
    initial begin : responder
        logic [31:0] cur_addr;
        int wait_left;
        bit pending;
        pending = 1'b0;
        cur_addr = 32'd0;
        wait_left = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pending = 1'b0;
                imem_ready = 1'b0;
                req_log.delete();
            end else begin
                if (imem_ready) pending = 1'b0;
                if (imem_req) begin
                    if (!pending) begin
                        pending = 1'b1;
                        cur_addr = imem_addr;
                        wait_left = (lat_mode == 4) ? int'($urandom_range(0, 3)) : lat_mode;
                        req_log.push_back(imem_addr);
                    end else begin
                        chk("req_addr_stable", imem_addr, cur_addr);
                    end
                    if (wait_left == 0) begin
                        imem_ready = 1'b1;
                        imem_rdata = mem_word(cur_addr);
                    end else begin
                        imem_ready = 1'b0;
                        imem_rdata = $urandom;
                        wait_left--;
                    end
                end else begin
                    if (pending) chk("req_dropped_while_pending", 32'(imem_req), 32'd1);
                    pending = 1'b0;
                    imem_ready = 1'b0;
                end
            end
        end
    end

    // Stimulus driver: stall pattern plus a control-unit stand-in decoding dec_opcode.
    initial begin : driver
        forever begin
            @(negedge clk);
            #1;
            if (stall_mode == 1) stall = ($urandom_range(0, 99) < 30);
            else                 stall = stall_man;
            if (ctl_mode == 0) begin
                branch_eq_i = 1'b0; branch_gr_i = 1'b0; jump_i = 1'b0;
                alu_zero_i = 1'b0;  alu_gt_i = 1'b0;
            end else begin
                branch_eq_i = (dec_opcode == 6'd4);
                branch_gr_i = (dec_opcode == 6'd7);
                jump_i      = (dec_opcode == 6'd2);
                alu_zero_i  = (ctl_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                alu_gt_i    = (ctl_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
    end

    // Scoreboard monitor: on every consume, compare decode against the expected
    // PC popped from the queue, then push the architecturally next PC.
    initial begin : monitor
        logic [31:0] p, w, nxt;
        logic signed [31:0] off;
        bit tk;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                exp_q.delete();
                exp_q.push_back(RST_PC);
                n_cons = 0;
                n_stall = 0;
                cyc = 0;
            end else begin
                cyc++;
                if (cyc % 16 == 0) begin
`ifdef FETCH_PERF_EN
                    chk("fetch_count", fetch_count, 32'(n_cons) + 32'(dec_valid));
                    chk("stall_count", stall_count, 32'(n_stall));
`else
                    chk("fetch_count_off", fetch_count, 32'd0);
                    chk("stall_count_off", stall_count, 32'd0);
`endif
                end
                if (dec_valid && stall) n_stall++;
                if (dec_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 32'd0, 32'd1);
                    end else begin
                        p = exp_q.pop_front();
                        w = mem_word(p);
                        chk("dec_pc", dec_pc, p);
                        chk("dec_instr", dec_instr, w);
                        chk("dec_opcode", 32'(dec_opcode), 32'(w[31:26]));
                        chk("dec_pc_plus4", dec_pc_plus4, p + 32'd4);
                        n_cons++;
                        tk = (branch_eq_i && alu_zero_i) || (branch_gr_i && alu_gt_i) || jump_i;
                        off = $signed(w[15:0]);
                        off = off * 4;
                        if (jump_i)   nxt = {p[31:28] + 4'd0, w[25:0], 2'b00};
                        else if (tk)  nxt = p + 32'd4 + off;
                        else          nxt = p + 32'd4;
                        if (jump_i) begin
                            nxt = p + 32'd4;
                            nxt = {nxt[31:28], w[25:0], 2'b00};
                        end
                        exp_q.push_back(nxt);
                    end
                end
            end
        end
    end

    // Main sequence: directed phases followed by a randomized soak.
    initial begin : main_seq
        logic [31:0] exp_seq [7];
        logic [31:0] w100;
        // Reset values while held in reset
        repeat (3) @(negedge clk);
        #5 chk_reset_vals("por");

        // Phase A: zero-wait memory, sequential fetch from RESET_PC
        lat_mode = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #5;
        chk("boot_req", 32'(imem_req), 32'd0);
        @(negedge clk); #5;
        chk("a_req1", 32'(imem_req), 32'd1);
        chk("a_addr1", imem_addr, 32'h100);
        chk("a_valid1", 32'(dec_valid), 32'd0);
        @(negedge clk); #5;
        w100 = mem_word(32'h100);
        chk("a_addr2", imem_addr, 32'h104);
        chk("a_valid2", 32'(dec_valid), 32'd1);
        chk("a_decpc2", dec_pc, 32'h100);
        chk("a_opcode2", 32'(dec_opcode), 32'(w100[31:26]));
        @(negedge clk); #5;
        chk("a_addr3", imem_addr, 32'h108);
        chk("a_decpc3", dec_pc, 32'h104);
        repeat (12) @(negedge clk);

        // Phase B: async reset mid-request, then a 3-wait-cycle memory
        lat_mode = 3;
        repeat (3) @(negedge clk);
        do_reset("midrst");
        @(negedge clk); #5;
        chk("b_boot_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #5;
            chk("b_req_hold", 32'(imem_req), 32'd1);
            chk("b_addr_hold", imem_addr, 32'h100);
            chk("b_valid_low", 32'(dec_valid), 32'd0);
        end
        @(negedge clk); #5;
        chk("b_valid_up", 32'(dec_valid), 32'd1);
        chk("b_decpc", dec_pc, 32'h100);
        chk("b_addr_next", imem_addr, 32'h104);
        repeat (10) @(negedge clk);

        // Phase C: stall while a response arrives -> skid buffer
        lat_mode = 0;
        do_reset("c_rst");
        @(negedge clk);                       // boot
        @(negedge clk);                       // request 0x100
        @(negedge clk); stall_man = 1'b1;     // 0x100 in decode, 0x104 arrives stalled
        @(negedge clk); #5;
        chk("c_skid_req_low", 32'(imem_req), 32'd0);
        chk("c_skid_decpc", dec_pc, 32'h100);
        @(negedge clk); stall_man = 1'b0; #5;
        chk("c_skid_req_low2", 32'(imem_req), 32'd0);
        @(negedge clk); #5;
        chk("c_resume_req", 32'(imem_req), 32'd1);
        chk("c_resume_addr", imem_addr, 32'h108);
        chk("c_skid_decpc2", dec_pc, 32'h104);
        chk("c_skid_instr", dec_instr, mem_word(32'h104));
        @(negedge clk); #5;
        chk("c_next_decpc", dec_pc, 32'h108);
        repeat (8) @(negedge clk);

        // Phase D: j 0x200 -> beq +4 taken -> j 0x100, slow memory squashes fall-through words
        ovr[32'h100] = {6'd2, 26'h000_0080};
        ovr[32'h200] = {6'd4, 5'd1, 5'd2, 16'h0004};
        ovr[32'h214] = {6'd2, 26'h000_0040};
        lat_mode = 2;
        ctl_mode = 1;
        do_reset("d_rst");
        repeat (45) @(negedge clk);
        #5;
        exp_seq = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h214, 32'h218, 32'h100};
        chk("d_req_count", 32'(req_log.size() >= 7), 32'd1);
        for (int i = 0; i < 7; i++) begin
            if (i < req_log.size()) chk("d_req_seq", req_log[i], exp_seq[i]);
        end

        // Phase E: randomized soak with random latency, stalls and branch outcomes
        ctl_mode = 2;
        lat_mode = 4;
        stall_mode = 1;
        do_reset("e_rst");
        repeat (3000) @(negedge clk);
        #5;
        chk("e_progress", 32'(n_cons > 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
